kernel_window_streamer: RTL and testbench
=========================================

Name: kernel_window_streamer

Overview:
- Parametrised frame buffer and window feeder for the edge-detection pipeline.
- Loads a frame LANES pixels per cycle, then streams K-row pixel columns (K = 3 or 5) to a downstream filter (median, Gaussian, Sobel, non-max, hysteresis). Border handling is selectable.
- Filter results are written back into a shadow bank. A commit swaps the shadow bank with the active bank, so passes can chain without a separate write-back step.

Parameters:
- IMG_W, 20, frame width in pixels.
- IMG_H, 20, frame height in pixels.
- PIX_W, 5, bits per pixel.
- LANES, 5, pixels accepted per load beat. IMG_W*IMG_H must be divisible by LANES.
- KMAX, 5, number of output column lanes (largest supported kernel).

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-high reset.
- pixel_in, input, LANES*PIX_W, load data. Lane 0 sits in the lowest bits and maps to the lowest raster address.
- in_valid, input, 1, load beat valid.
- in_ready, output, 1, high only in LOAD.
- frame_loaded, output, 1, high once all IMG_W*IMG_H pixels are loaded. Cleared by reset or reload.
- reload, input, 1, pulse in READY: return to LOAD.
- start, input, 1, pulse in READY: begin a scan pass.
- ksel, input, 1, 0 = 3x3 window, 1 = 5x5 window. Sampled when start is accepted.
- border, input, 2, border mode sampled at start: 0 = replicate, 1 = zero, 2 = valid-only, 3 = replicate.
- col_out, output, KMAX*PIX_W, registered column. Lane 0 is the top row of the window.
- col_valid, output, 1, col_out valid.
- col_ready, input, 1, downstream accepts col_out.
- col_first, output, 1, first column of the current output row.
- col_last, output, 1, last column of the current output row.
- row_last, output, 1, high with col_last on the final beat of the pass.
- busy, output, 1, high in SCAN.
- wb_en, input, 1, write to the shadow bank.
- wb_addr, input, clog2(IMG_W*IMG_H), raster address.
- wb_data, input, PIX_W, write-back data.
- commit, input, 1, pulse in READY: swap active and shadow banks.

Behaviour:
Reset (synchronous, active-high):
- Outputs go to 0, except in_ready = 1.
- State goes to LOAD; load counter = 0; active bank = 0.
- Pixel storage is not cleared.
- A reset mid-load or mid-scan aborts immediately. No further col_valid beats are produced.

State machine: LOAD -> READY -> SCAN -> READY.
- LOAD:
  - Each in_valid beat writes LANES pixels to the active bank at addr, addr+1, ... addr+LANES-1, then addr += LANES.
  - On the beat that writes address IMG_W*IMG_H-1: next state is READY, frame_loaded = 1, in_ready drops the next cycle.
  - start, commit and wb_en are ignored in LOAD.
- READY:
  - Priority order: reload > commit > start.
  - reload -> LOAD with counter = 0.
  - commit and start in the same cycle: the swap applies first, and the scan reads the new active bank.
  - start -> SCAN. The first col_valid appears the next cycle.
- SCAN:
  - h = 1 (ksel = 0) or 2 (ksel = 1). K = 2h+1.
  - Modes 0/1: output rows r = 0..IMG_H-1; columns x = -h..IMG_W-1+h, giving (IMG_W+2h) beats per row.
  - Mode 2: rows r = h..IMG_H-1-h; columns x = 0..IMG_W-1.
  - Lane j (j < K) carries pixel (r-h+j, x).
  - Out-of-frame coordinates: clamped to the frame in replicate mode; 0 in zero mode.
  - Lanes j >= K are driven to 0.
  - After the row_last beat is accepted, the next cycle col_valid = 0, busy = 0 and the state is READY. There are no bubbles between beats while col_ready is held high.
- Handshake:
  - A beat transfers when col_valid && col_ready.
  - While col_valid && !col_ready, col_out and all flags hold stable.
  - col_valid never drops without a transfer, except on reset.
- Write-back:
  - wb_en writes wb_data to the shadow bank at wb_addr in READY or SCAN.
  - Writes are ignored in LOAD, and ignored if wb_addr >= IMG_W*IMG_H.
  - A write in the same cycle as commit lands in the pre-swap shadow bank, i.e. the new active bank.
- Ignored requests:
  - start, commit and reload during SCAN are ignored (not queued).
  - ksel and border are ignored outside the start cycle.

Test Plan:
- Default parameters, load pixels p[i] = i mod 32 over 80 beats -> frame_loaded rises after beat 80; in_ready = 0 the cycle after.
- 3x3 replicate scan, col_ready tied high:
  - 440 beats; first beat lanes 0..2 = p[0], p[0], p[20]; col_first = 1 on beats 0, 22, 44, ...
  - Last beat row_last = 1 with lanes = p[379], p[399], p[399].
- 5x5 zero-border scan:
  - 480 beats; first beat lanes = 0, 0, 0, 0, 0.
  - Beat 2 (x = 0, r = 0) lanes = 0, 0, p[0], p[20], p[40].
- 3x3 valid-only scan -> 360 beats; lanes 3..4 = 0.
- Same scan with col_ready toggled in a pseudo-random pattern -> beat sequence identical to the col_ready-high run; outputs stable while stalled.
- Write-back and control corner cases:
  - wb_en writes 0x1F to all 400 addresses during a scan; then commit + start in the same cycle -> every lane = 0x1F.
  - reset asserted at beat 100 -> col_valid = 0 next cycle, in_ready = 1, frame_loaded = 0.

Source files
------------

// File: rtl/kernel_window_streamer.sv
// Frame buffer and K-row column feeder for the edge pipeline.
// Ports: pixel_in/in_valid/in_ready load, start/ksel/border scan,
//        col_* stream out, wb_* shadow write, commit bank swap.
module kernel_window_streamer #(
  parameter  int IMG_W = 20,
  parameter  int IMG_H = 20,
  parameter  int PIX_W = 5,
  parameter  int LANES = 5,
  parameter  int KMAX  = 5,
  localparam int NPIX  = IMG_W * IMG_H,
  localparam int AW    = $clog2(NPIX)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [LANES*PIX_W-1:0]   pixel_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     frame_loaded,
  input  logic                     reload,
  input  logic                     start,
  input  logic                     ksel,
  input  logic [1:0]               border,
  output logic [KMAX*PIX_W-1:0]    col_out,
  output logic                     col_valid,
  input  logic                     col_ready,
  output logic                     col_first,
  output logic                     col_last,
  output logic                     row_last,
  output logic                     busy,
  input  logic                     wb_en,
  input  logic [AW-1:0]            wb_addr,
  input  logic [PIX_W-1:0]         wb_data,
  input  logic                     commit
);

  typedef enum logic [1:0] {
    S_LOAD,
    S_READY,
    S_SCAN
  } state_t;

  localparam int CW = 16;
  typedef logic signed [CW-1:0] crd_t;

  localparam crd_t W_C = crd_t'(IMG_W);
  localparam crd_t H_C = crd_t'(IMG_H);
  localparam crd_t ONE = crd_t'(1);
  localparam logic [AW-1:0] LAST_BEAT =
    AW'(NPIX - LANES);
  localparam logic [AW-1:0] NPIX_A = AW'(NPIX);

  state_t state_q, state_d;

  logic [PIX_W-1:0] mem [2][NPIX];

  logic [AW-1:0] ld_addr_q;
  logic          act_q;
  logic          h2_q;
  logic          zero_q;
  logic          vo_q;
  logic          done_q;
  crd_t          r_q;
  crd_t          x_q;

  logic ld_fire, ld_done;
  logic rdy_reload, rdy_commit, rdy_start;
  logic scan_emit, scan_end, emit;
  logic wb_ok;

  assign ld_fire    = (state_q == S_LOAD) && in_valid;
  assign ld_done    = ld_fire && (ld_addr_q == LAST_BEAT);
  assign rdy_reload = (state_q == S_READY) && reload;
  assign rdy_commit = (state_q == S_READY) && !reload
                      && commit;
  assign rdy_start  = (state_q == S_READY) && !reload
                      && start;
  assign scan_emit  = (state_q == S_SCAN) && !done_q
                      && (!col_valid || col_ready);
  assign scan_end   = (state_q == S_SCAN) && done_q
                      && col_valid && col_ready;
  assign emit       = rdy_start || scan_emit;
  assign wb_ok      = wb_en && (state_q != S_LOAD)
                      && (wb_addr < NPIX_A);

  assign in_ready = (state_q == S_LOAD);
  assign busy     = (state_q == S_SCAN);

  // On the start cycle the first beat is built from the live
  // inputs so col_valid can rise on the very next cycle.
  logic sel_h2, sel_zero, sel_vo, sel_bank;
  crd_t hh, xmin, xmax, rmin, rmax;
  crd_t sel_r, sel_x;

  always_comb begin
    sel_h2   = rdy_start ? ksel : h2_q;
    sel_zero = rdy_start ? (border == 2'd1) : zero_q;
    sel_vo   = rdy_start ? (border == 2'd2) : vo_q;
    // A commit in the start cycle swaps first.
    sel_bank = rdy_commit ? ~act_q : act_q;
    hh       = sel_h2 ? crd_t'(2) : ONE;
    xmin     = sel_vo ? '0 : -hh;
    xmax     = sel_vo ? W_C - ONE : W_C - ONE + hh;
    rmin     = sel_vo ? hh : '0;
    rmax     = sel_vo ? H_C - ONE - hh : H_C - ONE;
    sel_r    = rdy_start ? rmin : r_q;
    sel_x    = rdy_start ? xmin : x_q;
  end

  logic b_first, b_last, b_rl;
  crd_t nx, nr;

  always_comb begin
    b_first = (sel_x == xmin);
    b_last  = (sel_x == xmax);
    b_rl    = b_last && (sel_r == rmax);
    nx      = b_last ? xmin : sel_x + ONE;
    nr      = b_last ? sel_r + ONE : sel_r;
  end

  logic [KMAX*PIX_W-1:0] beat;
  crd_t                  xc;
  logic                  x_oob;

  always_comb begin
    beat  = '0;
    x_oob = (sel_x < 0) || (sel_x >= W_C);
    if (sel_x < 0)
      xc = '0;
    else if (sel_x >= W_C)
      xc = W_C - ONE;
    else
      xc = sel_x;
    for (int j = 0; j < KMAX; j++) begin : g_lane
      crd_t             yy;
      crd_t             yc;
      logic [AW-1:0]    addr;
      logic [PIX_W-1:0] pix;
      logic             oob;
      yy  = sel_r - hh + crd_t'(j);
      oob = x_oob || (yy < 0) || (yy >= H_C);
      if (yy < 0)
        yc = '0;
      else if (yy >= H_C)
        yc = H_C - ONE;
      else
        yc = yy;
      addr = AW'(yc * W_C + xc);
      pix  = mem[sel_bank][addr];
      // Lanes beyond K = 2h+1 carry nothing.
      if (crd_t'(j) > hh + hh)
        pix = '0;
      else if (sel_zero && oob)
        pix = '0;
      beat[j*PIX_W +: PIX_W] = pix;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      state_q <= S_LOAD;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_LOAD: begin
        if (ld_done)
          state_d = S_READY;
      end
      S_READY: begin
        if (reload)
          state_d = S_LOAD;
        else if (start)
          state_d = S_SCAN;
      end
      S_SCAN: begin
        if (scan_end)
          state_d = S_READY;
      end
      default: state_d = S_LOAD;
    endcase
  end

  // Pixel storage is never cleared; reset only blocks writes.
  always_ff @(posedge clk) begin
    if (!reset && ld_fire) begin
      for (int l = 0; l < LANES; l++)
        mem[act_q][ld_addr_q + AW'(l)] <=
          pixel_in[l*PIX_W +: PIX_W];
    end
    if (!reset && wb_ok)
      mem[~act_q][wb_addr] <= wb_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ld_addr_q    <= '0;
      act_q        <= 1'b0;
      frame_loaded <= 1'b0;
      h2_q         <= 1'b0;
      zero_q       <= 1'b0;
      vo_q         <= 1'b0;
      done_q       <= 1'b0;
      r_q          <= '0;
      x_q          <= '0;
      col_out      <= '0;
      col_valid    <= 1'b0;
      col_first    <= 1'b0;
      col_last     <= 1'b0;
      row_last     <= 1'b0;
    end else begin
      if (ld_fire) begin
        ld_addr_q <= ld_done ? '0
                     : ld_addr_q + AW'(LANES);
        if (ld_done)
          frame_loaded <= 1'b1;
      end
      if (rdy_reload) begin
        ld_addr_q    <= '0;
        frame_loaded <= 1'b0;
      end
      if (rdy_commit)
        act_q <= ~act_q;
      if (rdy_start) begin
        h2_q   <= ksel;
        zero_q <= (border == 2'd1);
        vo_q   <= (border == 2'd2);
      end
      if (emit) begin
        col_valid <= 1'b1;
        col_out   <= beat;
        col_first <= b_first;
        col_last  <= b_last;
        row_last  <= b_rl;
        r_q       <= nr;
        x_q       <= nx;
        done_q    <= b_rl;
      end else if (scan_end) begin
        col_valid <= 1'b0;
        col_first <= 1'b0;
        col_last  <= 1'b0;
        row_last  <= 1'b0;
        done_q    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_kernel_window_streamer.sv
// Directed bench for kernel_window_streamer.
// Loads a ramp frame and checks scans, stalls, write-back, reset.
module tb_kernel_window_streamer;

  localparam int W  = 20;
  localparam int H  = 20;
  localparam int PW = 5;
  localparam int LN = 5;
  localparam int KM = 5;
  localparam int N  = W * H;
  localparam int AW = 9;
  localparam int MAXB = 600;

  logic              clk;
  logic              reset;
  logic [LN*PW-1:0]  pixel_in;
  logic              in_valid;
  logic              in_ready;
  logic              frame_loaded;
  logic              reload;
  logic              start;
  logic              ksel;
  logic [1:0]        border;
  logic [KM*PW-1:0]  col_out;
  logic              col_valid;
  logic              col_ready;
  logic              col_first;
  logic              col_last;
  logic              row_last;
  logic              busy;
  logic              wb_en;
  logic [AW-1:0]     wb_addr;
  logic [PW-1:0]     wb_data;
  logic              commit;

  kernel_window_streamer dut (
    .clk          (clk),
    .reset        (reset),
    .pixel_in     (pixel_in),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .frame_loaded (frame_loaded),
    .reload       (reload),
    .start        (start),
    .ksel         (ksel),
    .border       (border),
    .col_out      (col_out),
    .col_valid    (col_valid),
    .col_ready    (col_ready),
    .col_first    (col_first),
    .col_last     (col_last),
    .row_last     (row_last),
    .busy         (busy),
    .wb_en        (wb_en),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .commit       (commit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [PW-1:0]    ref_mem [N];

  logic [KM*PW-1:0] exp_col [MAXB];
  logic [2:0]       exp_flg [MAXB];
  int               exp_n;

  logic [KM*PW-1:0] got_col [MAXB];
  logic [2:0]       got_flg [MAXB];
  int               got_n;
  int               stall_err;
  logic             end_valid;
  logic             end_busy;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference window walk: nested row/column loops over ref_mem.
  function automatic void build_expected(
    input logic ks, input logic [1:0] bd);
    int h, k, r0, r1, x0, x1, yy, yc, xc;
    logic [KM*PW-1:0] col;
    logic [PW-1:0]    pix;
    h = ks ? 2 : 1;
    k = 2 * h + 1;
    if (bd == 2'd2) begin
      r0 = h; r1 = H - 1 - h; x0 = 0; x1 = W - 1;
    end else begin
      r0 = 0; r1 = H - 1; x0 = -h; x1 = W - 1 + h;
    end
    exp_n = 0;
    for (int r = r0; r <= r1; r++) begin
      for (int x = x0; x <= x1; x++) begin
        col = '0;
        for (int j = 0; j < k; j++) begin
          yy = r - h + j;
          if (yy >= 0 && yy < H && x >= 0 && x < W)
            pix = ref_mem[yy*W + x];
          else if (bd == 2'd1)
            pix = '0;
          else begin
            yc = (yy < 0) ? 0 : ((yy >= H) ? H - 1 : yy);
            xc = (x < 0) ? 0 : ((x >= W) ? W - 1 : x);
            pix = ref_mem[yc*W + xc];
          end
          col[j*PW +: PW] = pix;
        end
        exp_col[exp_n] = col;
        exp_flg[exp_n] = {x == x0, x == x1,
                          (x == x1) && (r == r1)};
        exp_n++;
      end
    end
  endfunction

  task automatic run_scan(
    input logic ks, input logic [1:0] bd,
    input bit stall, input bit wb_all,
    input bit do_commit, input int expn);
    int cyc;
    bit hold;
    logic rdy;
    logic [7:0] lf;
    logic [KM*PW+3:0] saved;
    got_n = 0;
    stall_err = 0;
    hold = 0;
    saved = '0;
    lf = 8'hA5;
    ksel = ks;
    border = bd;
    start = 1'b1;
    commit = do_commit;
    tick();
    start = 1'b0;
    commit = 1'b0;
    ksel = ~ks;
    border = ~bd;
    cyc = 0;
    while (got_n < expn && cyc < 5000) begin
      if (hold && saved !== {col_valid, col_first,
                             col_last, row_last, col_out})
        stall_err++;
      lf = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
      rdy = stall ? lf[0] : 1'b1;
      col_ready = rdy;
      if (wb_all && cyc < N) begin
        wb_en = 1'b1;
        wb_addr = AW'(cyc);
        wb_data = 5'h1F;
      end else begin
        wb_en = 1'b0;
      end
      if (col_valid && rdy) begin
        got_col[got_n] = col_out;
        got_flg[got_n] = {col_first, col_last, row_last};
        got_n++;
      end
      hold = col_valid && !rdy;
      saved = {col_valid, col_first, col_last,
               row_last, col_out};
      tick();
      cyc++;
    end
    wb_en = 1'b0;
    col_ready = 1'b1;
    end_valid = col_valid;
    end_busy = busy;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 1",
               in_ready);
    end
    n_checks++;
    if ({frame_loaded, col_valid, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 000",
               {frame_loaded, col_valid, busy});
    end
    n_checks++;
    if ({col_out, col_first, col_last, row_last} !== '0)
    begin
      n_fail++;
      $display("FAIL reset_col: got %h want 0", col_out);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_load();
    for (int b = 0; b < N / LN; b++) begin
      for (int l = 0; l < LN; l++) begin
        pixel_in[l*PW +: PW] = PW'((b*LN + l) % 32);
        ref_mem[b*LN + l] = PW'((b*LN + l) % 32);
      end
      in_valid = 1'b1;
      if (b == N / LN - 1) begin
        n_checks++;
        if ({frame_loaded, in_ready} !== 2'b01) begin
          n_fail++;
          $display("FAIL load_pre_last: got %b want 01",
                   {frame_loaded, in_ready});
        end
      end
      tick();
    end
    in_valid = 1'b0;
    n_checks++;
    if (frame_loaded !== 1'b1) begin
      n_fail++;
      $display("FAIL load_done: got %b want 1",
               frame_loaded);
    end
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL load_in_ready: got %b want 0",
               in_ready);
    end
  endtask

  task automatic test_scan3_replicate();
    build_expected(1'b0, 2'd0);
    run_scan(1'b0, 2'd0, 0, 0, 0, 440);
    n_checks++;
    if (got_n !== 440) begin
      n_fail++;
      $display("FAIL s3r_count: got %0d want 440", got_n);
    end
    n_checks++;
    if (got_col[0] !== {5'd0, 5'd0, 5'd20, 5'd0, 5'd0})
    begin
      n_fail++;
      $display("FAIL s3r_first: got %h", got_col[0]);
    end
    n_checks++;
    if ({got_flg[0][2], got_flg[1][2], got_flg[22][2],
         got_flg[44][2]} !== 4'b1011) begin
      n_fail++;
      $display("FAIL s3r_col_first: got %b want 1011",
               {got_flg[0][2], got_flg[1][2],
                got_flg[22][2], got_flg[44][2]});
    end
    n_checks++;
    if ({got_flg[439], got_col[439]} !==
        {3'b011, 5'd0, 5'd0, 5'd15, 5'd15, 5'd27}) begin
      n_fail++;
      $display("FAIL s3r_last: got %b %h", got_flg[439],
               got_col[439]);
    end
    n_checks++;
    if ({end_valid, end_busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL s3r_end: got %b want 00",
               {end_valid, end_busy});
    end
    for (int i = 0; i < got_n; i++) begin
      n_checks++;
      if ({got_flg[i], got_col[i]} !==
          {exp_flg[i], exp_col[i]}) begin
        n_fail++;
        $display("FAIL s3r_beat%0d: got %b %h want %b %h",
                 i, got_flg[i], got_col[i],
                 exp_flg[i], exp_col[i]);
      end
    end
  endtask

  task automatic test_scan5_zero();
    build_expected(1'b1, 2'd1);
    run_scan(1'b1, 2'd1, 0, 0, 0, 480);
    n_checks++;
    if (got_n !== 480) begin
      n_fail++;
      $display("FAIL s5z_count: got %0d want 480", got_n);
    end
    n_checks++;
    if (got_col[0] !== '0) begin
      n_fail++;
      $display("FAIL s5z_first: got %h want 0",
               got_col[0]);
    end
    n_checks++;
    if (got_col[2] !== {5'd8, 5'd20, 5'd0, 5'd0, 5'd0})
    begin
      n_fail++;
      $display("FAIL s5z_beat2: got %h", got_col[2]);
    end
    for (int i = 0; i < got_n; i++) begin
      n_checks++;
      if ({got_flg[i], got_col[i]} !==
          {exp_flg[i], exp_col[i]}) begin
        n_fail++;
        $display("FAIL s5z_beat%0d: got %b %h want %b %h",
                 i, got_flg[i], got_col[i],
                 exp_flg[i], exp_col[i]);
      end
    end
  endtask

  task automatic test_scan3_valid(input bit stall);
    int hi;
    build_expected(1'b0, 2'd2);
    run_scan(1'b0, 2'd2, stall, 0, 0, 360);
    n_checks++;
    if (got_n !== 360) begin
      n_fail++;
      $display("FAIL s3v_count: got %0d want 360", got_n);
    end
    n_checks++;
    if (got_col[0] !== {5'd0, 5'd0, 5'd8, 5'd20, 5'd0})
    begin
      n_fail++;
      $display("FAIL s3v_first: got %h", got_col[0]);
    end
    hi = 0;
    for (int i = 0; i < got_n; i++)
      if (got_col[i][KM*PW-1:3*PW] !== '0)
        hi++;
    n_checks++;
    if (hi !== 0) begin
      n_fail++;
      $display("FAIL s3v_upper_lanes: got %0d want 0", hi);
    end
    n_checks++;
    if (stall_err !== 0) begin
      n_fail++;
      $display("FAIL s3v_stall_hold: got %0d want 0",
               stall_err);
    end
    for (int i = 0; i < got_n; i++) begin
      n_checks++;
      if ({got_flg[i], got_col[i]} !==
          {exp_flg[i], exp_col[i]}) begin
        n_fail++;
        $display("FAIL s3v_beat%0d: got %b %h want %b %h",
                 i, got_flg[i], got_col[i],
                 exp_flg[i], exp_col[i]);
      end
    end
  endtask

  task automatic test_writeback_commit();
    build_expected(1'b0, 2'd0);
    run_scan(1'b0, 2'd0, 0, 1, 0, 440);
    n_checks++;
    if (got_col[439] !==
        {5'd0, 5'd0, 5'd15, 5'd15, 5'd27}) begin
      n_fail++;
      $display("FAIL wb_active_untouched: got %h",
               got_col[439]);
    end
    for (int i = 0; i < N; i++)
      ref_mem[i] = 5'h1F;
    build_expected(1'b0, 2'd0);
    run_scan(1'b0, 2'd0, 0, 0, 1, 440);
    n_checks++;
    if (got_n !== 440) begin
      n_fail++;
      $display("FAIL wb_count: got %0d want 440", got_n);
    end
    n_checks++;
    if (got_col[0] !== {5'd0, 5'd0, 5'd31, 5'd31, 5'd31})
    begin
      n_fail++;
      $display("FAIL wb_first: got %h", got_col[0]);
    end
    for (int i = 0; i < got_n; i++) begin
      n_checks++;
      if ({got_flg[i], got_col[i]} !==
          {exp_flg[i], exp_col[i]}) begin
        n_fail++;
        $display("FAIL wb_beat%0d: got %b %h want %b %h",
                 i, got_flg[i], got_col[i],
                 exp_flg[i], exp_col[i]);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    int n;
    int cyc;
    ksel = 1'b0;
    border = 2'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    cyc = 0;
    while (n < 100 && cyc < 1000) begin
      if (col_valid)
        n++;
      tick();
      cyc++;
    end
    n_checks++;
    if (col_valid !== 1'b1 || n !== 100) begin
      n_fail++;
      $display("FAIL mid_scan_reach: got %b/%0d want 1/100",
               col_valid, n);
    end
    reset = 1'b1;
    tick();
    n_checks++;
    if ({col_valid, in_ready, frame_loaded, busy} !==
        4'b0100) begin
      n_fail++;
      $display("FAIL mid_reset: got %b want 0100",
               {col_valid, in_ready, frame_loaded, busy});
    end
    reset = 1'b0;
    tick();
    tick();
    tick();
    n_checks++;
    if ({col_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL post_reset: got %b want 01",
               {col_valid, in_ready});
    end
  endtask

  initial begin
    reset = 1'b1;
    pixel_in = '0;
    in_valid = 1'b0;
    reload = 1'b0;
    start = 1'b0;
    ksel = 1'b0;
    border = 2'd0;
    col_ready = 1'b1;
    wb_en = 1'b0;
    wb_addr = '0;
    wb_data = '0;
    commit = 1'b0;
    test_reset();
    test_load();
    test_scan3_replicate();
    test_scan5_zero();
    test_scan3_valid(0);
    test_scan3_valid(1);
    test_writeback_commit();
    test_reset_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
